// File: rtl/blake_finalize.sv
// BLAKE-512 finalisation: captures v/h when the round counter completes, folds them
// into the digest, then streams it. Optional target compare: BLAKE_FINALIZE_TARGET_CMP_EN.
module blake_finalize #(
  parameter int WORD_ORDER = 0
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          count_done,
  input  logic [1023:0] v_state,
  input  logic [511:0]  h_in,
  output logic          busy,
  output logic [511:0]  digest,
  output logic          digest_valid,
  output logic [63:0]   dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          overrun
`ifdef BLAKE_FINALIZE_TARGET_CMP_EN
  ,
  input  logic [63:0]   target,
  output logic          hit,
  output logic          hit_stb
`endif
);

  typedef enum logic [1:0] {IDLE, FOLD, SEND} state_t;

  state_t          state;
  logic [1023:0]   v_q;
  logic [511:0]    h_q;
  logic [2:0]      beat;
  logic [511:0]    fold_val;

  // Salt is zero, so the fold reduces to h ^ upper half of v ^ lower half of v.
  assign fold_val = h_q ^ v_q[1023:512] ^ v_q[511:0];
  assign busy     = (state != IDLE);

  // Word 0 sits at the top of the digest; WORD_ORDER=1 walks the lanes backwards.
  function automatic logic [63:0] word_sel(input logic [511:0] d, input logic [2:0] idx);
    logic [2:0] lane;
    logic [8:0] pos;
    lane = (WORD_ORDER == 0) ? idx : (3'd7 - idx);
    pos  = {~lane, 6'b0};
    return d[pos +: 64];
  endfunction

  // NOTE: every register here is updated with <= so all state advances on the same
  // edge regardless of statement order; a blocking '=' would leak new values within the block.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      // NOTE: the wide capture and digest registers are reset too, so a reset
      // mid-stream leaves no stale digest visible on the outputs.
      state        <= IDLE;
      v_q          <= '0;
      h_q          <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      dout_last    <= 1'b0;
      beat         <= '0;
      overrun      <= 1'b0;
`ifdef BLAKE_FINALIZE_TARGET_CMP_EN
      hit          <= 1'b0;
      hit_stb      <= 1'b0;
`endif
    end else begin
      overrun <= count_done && (state != IDLE);
`ifdef BLAKE_FINALIZE_TARGET_CMP_EN
      hit_stb <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (count_done) begin
            v_q   <= v_state;
            h_q   <= h_in;
            state <= FOLD;
          end
        end
        FOLD: begin
          digest       <= fold_val;
          digest_valid <= 1'b1;
          beat         <= '0;
          dout         <= word_sel(fold_val, 3'd0);
          dout_valid   <= 1'b1;
          dout_last    <= 1'b0;
          state        <= SEND;
`ifdef BLAKE_FINALIZE_TARGET_CMP_EN
          hit          <= (fold_val[63:0] <= target);
          hit_stb      <= (fold_val[63:0] <= target);
`endif
        end
        SEND: begin
          // dout_valid is constantly high in SEND, so dout_ready alone is the handshake.
          if (dout_ready) begin
            if (beat == 3'd7) begin
              dout_valid   <= 1'b0;
              dout_last    <= 1'b0;
              digest_valid <= 1'b0;
              state        <= IDLE;
            end else begin
              beat      <= beat + 3'd1;
              dout      <= word_sel(digest, beat + 3'd1);
              dout_last <= (beat == 3'd6);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/blake_finalize.md
Name: blake_finalize

Overview:
- Output end of the BLAKE-512 compression core.
- When the round counter finishes, it captures the final 1024-bit working state v and the 512-bit chain value h.
- It folds them into the 512-bit digest h'[i] = h[i] ^ v[i] ^ v[i+8], with salt fixed at zero.
- It then streams the digest as eight 64-bit words over a valid/ready interface, and also presents the full digest in parallel.

Parameters:
- WORD_ORDER, 0, stream order. 0 = word 0 (digest[511:448]) first; 1 = word 7 (digest[63:0]) first.

Ports:
- clk  input  1  core clock
- rstb  input  1  asynchronous active-low reset
- count_done  input  1  single-cycle pulse: round sequence complete, v_state final
- v_state  input  1024  final working state; v[0] at [1023:960], v[15] at [63:0]
- h_in  input  512  chain value; h[0] at [511:448]
- busy  output  1  high whenever the FSM is not in IDLE
- digest  output  512  folded digest register
- digest_valid  output  1  high from FOLD completion until the last beat is accepted
- dout  output  64  stream word
- dout_valid  output  1  stream word valid
- dout_ready  input  1  downstream accept
- dout_last  output  1  high with the 8th beat
- overrun  output  1  one-cycle pulse: count_done arrived while busy

Behaviour:
- Reset (rstb low, asynchronous) sets:
  - FSM to IDLE
  - all capture registers, digest, dout, beat counter to 0
  - busy, digest_valid, dout_valid, dout_last, overrun to 0
- Reset mid-stream abandons the current digest with no further beats.
- FSM states:
  - IDLE: on count_done, register v_state and h_in, then go to FOLD.
  - FOLD: one cycle. Compute digest = h ^ v[1023:512] ^ v[511:0] (bitwise, 64-bit lanes aligned), set digest_valid, load beat counter = 0, go to SEND.
  - SEND: dout_valid = 1. dout is word(beat) per WORD_ORDER and is registered, changing only after a handshake.
    - On dout_valid & dout_ready: beat counter increments.
    - On beat 7 accepted: clear dout_valid, dout_last and digest_valid, return to IDLE.
- Latency: count_done sampled at edge N → FOLD during cycle N+1 → digest_valid and first dout_valid visible after edge N+2. Minimum 10 cycles from count_done to ready for the next count_done when dout_ready is held high.
- dout_last = dout_valid & (beat counter == 7).
- Backpressure: while dout_valid & !dout_ready, dout, dout_last and the counter hold unchanged. dout_valid never drops before acceptance.
- count_done while busy (FOLD or SEND): the input is ignored, the captured state is unaffected, and overrun pulses for one cycle.
- count_done in the same cycle as the final-beat acceptance counts as busy: it is dropped and overrun pulses. The core does not issue count_done back-to-back like this.
- Beat counter is 3 bits. It never wraps within a digest because the FSM leaves SEND on beat 7.
- digest holds its value after returning to IDLE, but digest_valid is 0 then.

Optional Feature:
- Macro BLAKE_FINALIZE_TARGET_CMP_EN.
- When defined, the following are added:
  - input target [63:0]
  - output hit (1 bit, reset 0)
- In FOLD, hit is registered as (digest word 7, i.e. h'[7] = [63:0], as an unsigned value) <= target. It holds until the next FOLD.
- hit also asserts a one-cycle pulse output hit_stb, coinciding with the first cycle of digest_valid.
- When undefined, these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
- Identity fold: h_in = IV(6A09E667F3BCC908…5BE0CD19137E2179), v_state = 0, count_done pulse, dout_ready = 1 → digest == IV, beats 6A09E667F3BCC908 … 5BE0CD19137E2179 in order, dout_last on beat 8, busy low 10 cycles after count_done.
- Lane fold: h_in = 0, v[15:8] all-ones, v[7:0] = 0 → digest all-ones. Then v[0] = 0123456789ABCDEF, v[8] = same → digest word 0 == 0 XOR pattern cancels to FFFF…FFFF for that lane only if h = ones; check the exact per-lane XOR.
- Backpressure: dout_ready toggled 1,0,0,1 per cycle → every word appears exactly once, dout stable during stalls, exactly 8 handshakes.
- Overrun: second count_done during beat 3 → overrun one-cycle pulse, streamed words unchanged from the first digest.
- Reset mid-SEND: rstb low after beat 4 → all outputs 0 immediately. A new count_done after release yields a full 8-beat stream.
- WORD_ORDER = 1 and TARGET_CMP_EN with target = FFFFFFFFFFFFFFFF → first beat is digest[63:0]; hit = 1 and hit_stb pulses. With target = 0 and a nonzero word 7 → hit = 0.
